// File: rtl/rr_seq_arbiter.sv
// Round-robin arbiter and sequencer for one shared multi-cycle resource:
// fair owner pick, setup countdown, held grant, then one recovery cycle.
module rr_seq_arbiter #(
  parameter int unsigned N            = 4,
  parameter int unsigned SETUP_CYCLES = 3,
  parameter int unsigned TIMEOUT      = 255,
  localparam int unsigned OW          = (N <= 2) ? 1 : $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  rel,
  output logic [N-1:0]  gnt,
  output logic          ready,
  output logic          busy,
  output logic [OW-1:0] owner,
  output logic          timeout_err
);

  localparam int unsigned IW = OW + 1;
  localparam int unsigned SW = 8;
  localparam int unsigned TW = 16;
  localparam logic [N-1:0]  GNT_ONE = {{(N-1){1'b0}}, 1'b1};
  localparam logic [TW-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACTIVE, S_RECOVER} state_t;

  state_t          state, state_nx;
  logic [N-1:0]    gnt_nx;
  logic            ready_nx, busy_nx, terr_nx;
  logic [OW-1:0]   owner_nx, ptr, ptr_nx, sel, ptr_after;
  logic [SW-1:0]   scnt, scnt_nx;
  logic [TW-1:0]   tcnt, tcnt_nx;
  logic [IW-1:0]   idx;
  logic            found, req_own, rel_own, to_hit;

  // First requester at or above the pointer, wrapping modulo N.
  always_comb begin
    sel   = ptr;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = IW'(ptr) + IW'(i);
      if (idx >= IW'(N)) idx = idx - IW'(N);
      if (!found && req[idx[OW-1:0]]) begin
        found = 1'b1;
        sel   = idx[OW-1:0];
      end
    end
  end

  assign ptr_after = (owner == OW'(N - 1)) ? '0 : owner + OW'(1);
  assign req_own   = req[owner];
  assign rel_own   = rel[owner];
  assign to_hit    = (TIMEOUT != 0) && (tcnt == TO_LAST);

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_nx = state;
    gnt_nx   = gnt;
    ready_nx = ready;
    busy_nx  = busy;
    owner_nx = owner;
    terr_nx  = 1'b0;
    ptr_nx   = ptr;
    scnt_nx  = scnt;
    tcnt_nx  = tcnt;
    case (state)
      S_IDLE: begin
        if (found) begin
          state_nx = S_SETUP;
          owner_nx = sel;
          gnt_nx   = GNT_ONE << sel;
          busy_nx  = 1'b1;
          scnt_nx  = SW'(SETUP_CYCLES - 1);
        end
      end
      S_SETUP: begin
        if (!req_own) begin
          state_nx = S_RECOVER;
          gnt_nx   = '0;
          ptr_nx   = ptr_after;
        end else if (scnt == '0) begin
          state_nx = S_ACTIVE;
          ready_nx = 1'b1;
          tcnt_nx  = '0;
        end else begin
          scnt_nx  = scnt - SW'(1);
        end
      end
      S_ACTIVE: begin
        if (rel_own || !req_own || to_hit) begin
          state_nx = S_RECOVER;
          gnt_nx   = '0;
          ready_nx = 1'b0;
          ptr_nx   = ptr_after;
          // Forced release only when nothing else ended the ownership.
          terr_nx  = to_hit && !rel_own && req_own;
        end else if (tcnt != '1) begin
          tcnt_nx  = tcnt + TW'(1);
        end
      end
      S_RECOVER: begin
        state_nx = S_IDLE;
        busy_nx  = 1'b0;
      end
      default: begin
        state_nx = S_IDLE;
        gnt_nx   = '0;
        ready_nx = 1'b0;
        busy_nx  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      gnt         <= '0;
      ready       <= 1'b0;
      busy        <= 1'b0;
      owner       <= '0;
      timeout_err <= 1'b0;
      ptr         <= '0;
      scnt        <= '0;
      tcnt        <= '0;
    end else begin
      state       <= state_nx;
      gnt         <= gnt_nx;
      ready       <= ready_nx;
      busy        <= busy_nx;
      owner       <= owner_nx;
      timeout_err <= terr_nx;
      ptr         <= ptr_nx;
      scnt        <= scnt_nx;
      tcnt        <= tcnt_nx;
    end
  end

endmodule

// File: tb/tb_rr_seq_arbiter.sv
// Self-checking bench for rr_seq_arbiter (N=4, SETUP_CYCLES=3, TIMEOUT=8).
module tb_rr_seq_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req, rel, gnt;
  logic       ready, busy, timeout_err;
  logic [1:0] owner;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0] req;
    logic [3:0] rel;
    logic [3:0] gnt;
    logic       ready;
    logic       busy;
    logic [1:0] owner;
    logic       terr;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];

  rr_seq_arbiter #(.N(4), .SETUP_CYCLES(3), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .req(req), .rel(rel), .gnt(gnt),
    .ready(ready), .busy(busy), .owner(owner), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic [3:0] rq, input logic [3:0] rl,
                              input logic [3:0] g, input logic rd, input logic b,
                              input logic [1:0] o, input logic t);
    vec_t v;
    v.req = rq; v.rel = rl; v.gnt = g; v.ready = rd; v.busy = b; v.owner = o; v.terr = t;
    return v;
  endfunction

  // One ownership slot: grant, setup, nact ACTIVE cycles, then rel or timeout exit, then recover.
  task automatic add_slot(input logic [3:0] rq, input logic [1:0] own, input int nact,
                          input logic [3:0] junk, input logic to);
    logic [3:0] oh;
    oh = 4'b0001 << own;
    for (int i = 0; i < 3; i++) tbl.push_back(mk(rq, 4'b0000, oh, 1'b0, 1'b1, own, 1'b0));
    for (int i = 0; i < nact; i++) tbl.push_back(mk(rq, junk, oh, 1'b1, 1'b1, own, 1'b0));
    tbl.push_back(mk(rq, to ? 4'b0000 : oh, 4'b0000, 1'b0, 1'b1, own, to));
    tbl.push_back(mk(rq, 4'b0000, 4'b0000, 1'b0, 1'b0, own, 1'b0));
  endtask

  task automatic step(input vec_t v, input string name);
    vec_t e;
    @(negedge clk);
    req = v.req;
    rel = v.rel;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    n_checks++;
    if (gnt !== e.gnt || ready !== e.ready || busy !== e.busy ||
        owner !== e.owner || timeout_err !== e.terr) begin
      n_fail++;
      $display("FAIL %s: got gnt=%b ready=%b busy=%b owner=%0d terr=%b, want gnt=%b ready=%b busy=%b owner=%0d terr=%b",
               name, gnt, ready, busy, owner, timeout_err,
               e.gnt, e.ready, e.busy, e.owner, e.terr);
    end
  endtask

  task automatic check_idle(input string name, input logic [1:0] own);
    n_checks++;
    if (gnt !== 4'b0000 || ready !== 1'b0 || busy !== 1'b0 ||
        owner !== own || timeout_err !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: got gnt=%b ready=%b busy=%b owner=%0d terr=%b, want all zero owner=%0d",
               name, gnt, ready, busy, owner, timeout_err, own);
    end
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    rel = '0;

    // Full rotation, pointer-skip, basic single requester, timeout and rel/timeout coincidence.
    add_slot(4'b1111, 2'd0, 1, 4'b0000, 1'b0);
    add_slot(4'b1111, 2'd1, 1, 4'b0000, 1'b0);
    add_slot(4'b1111, 2'd2, 1, 4'b0000, 1'b0);
    add_slot(4'b1111, 2'd3, 1, 4'b0000, 1'b0);
    add_slot(4'b1111, 2'd0, 1, 4'b0000, 1'b0);
    add_slot(4'b0101, 2'd2, 2, 4'b0001, 1'b0);
    add_slot(4'b0101, 2'd0, 2, 4'b0100, 1'b0);
    add_slot(4'b0001, 2'd0, 2, 4'b0000, 1'b0);
    add_slot(4'b1010, 2'd1, 8, 4'b0000, 1'b1);
    add_slot(4'b1010, 2'd3, 8, 4'b0000, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    check_idle("reset_state", 2'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));

    // Owner 3 withdraws during SETUP: abort without ready or timeout_err.
    step(mk(4'b1000, 4'b0000, 4'b1000, 1'b0, 1'b1, 2'd3, 1'b0), "abort_gnt");
    step(mk(4'b1000, 4'b0000, 4'b1000, 1'b0, 1'b1, 2'd3, 1'b0), "abort_setup");
    step(mk(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd3, 1'b0), "abort_recover");
    step(mk(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd3, 1'b0), "abort_idle");
    step(mk(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd3, 1'b0), "idle_hold");

    // Owner 1 moves the pointer to 2, then owner 2 is reset mid-ACTIVE.
    step(mk(4'b0010, 4'b0000, 4'b0010, 1'b0, 1'b1, 2'd1, 1'b0), "pre_gnt");
    step(mk(4'b0010, 4'b0000, 4'b0010, 1'b0, 1'b1, 2'd1, 1'b0), "pre_s1");
    step(mk(4'b0010, 4'b0000, 4'b0010, 1'b0, 1'b1, 2'd1, 1'b0), "pre_s2");
    step(mk(4'b0010, 4'b0000, 4'b0010, 1'b1, 1'b1, 2'd1, 1'b0), "pre_act");
    step(mk(4'b0010, 4'b0010, 4'b0000, 1'b0, 1'b1, 2'd1, 1'b0), "pre_rel");
    step(mk(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd1, 1'b0), "pre_idle");
    step(mk(4'b0100, 4'b0000, 4'b0100, 1'b0, 1'b1, 2'd2, 1'b0), "rst_gnt");
    step(mk(4'b0100, 4'b0000, 4'b0100, 1'b0, 1'b1, 2'd2, 1'b0), "rst_s1");
    step(mk(4'b0100, 4'b0000, 4'b0100, 1'b0, 1'b1, 2'd2, 1'b0), "rst_s2");
    step(mk(4'b0100, 4'b0000, 4'b0100, 1'b1, 1'b1, 2'd2, 1'b0), "rst_act");
    #2;
    rst = 1'b1;
    req = 4'b0000;
    #1;
    check_idle("async_reset", 2'd0);
    @(negedge clk);
    rst = 1'b0;
    step(mk(4'b0110, 4'b0000, 4'b0010, 1'b0, 1'b1, 2'd1, 1'b0), "post_rst_ptr0");
    step(mk(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd1, 1'b0), "post_rst_abort");
    step(mk(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd1, 1'b0), "post_rst_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_seq_arbiter.md
Name: rr_seq_arbiter

Overview:
Round-robin arbiter and sequencer for one shared multi-cycle resource. The resource needs a fixed setup interval before it is usable, and then stays owned until the owner releases it. The block accepts requests from N clients, picks one owner fairly and runs the setup countdown. It holds the grant until release, timeout or request withdrawal, then inserts one recovery cycle before the next arbitration.

Parameters:
N, 4, number of requesters (2..16)
SETUP_CYCLES, 3, cycles from grant to resource ready (1..255)
TIMEOUT, 255, max cycles in ACTIVE before forced release; 0 disables the timeout (0..65535)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
req  input  N  per-requester request level; held high while the resource is wanted
rel  input  N  per-requester release pulse; only rel[owner] is honoured
gnt  output N  one-hot grant; all zero when no owner
ready  output 1  resource usable by owner (ACTIVE state)
busy  output 1  high in SETUP, ACTIVE and RECOVER
owner  output OW  index of current/last owner; OW = max(1, ceil(log2 N))
timeout_err  output 1  one-cycle pulse on forced release

Behaviour:
- Reset (async, rst=1): state=IDLE; gnt=0, ready=0, busy=0, owner=0, timeout_err=0; rr pointer=0; setup and timeout counters=0.
- All outputs are registered, with no combinational path from inputs to outputs.
- States: IDLE, SETUP, ACTIVE, RECOVER.
- IDLE:
  - If req != 0, select the first set bit searching upward from pointer, wrapping modulo N.
  - Next cycle: owner=selected, gnt=one-hot(selected), busy=1, state=SETUP, setup counter=SETUP_CYCLES-1.
  - If req == 0, stay in IDLE.
- SETUP:
  - Counter decrements each cycle; when it is 0, go to ACTIVE and set ready=1.
  - Latency: req rising in IDLE at edge k gives gnt at edge k+1 and ready at edge k+1+SETUP_CYCLES.
  - If req[owner] drops during SETUP, abort to RECOVER (gnt=0, no timeout_err).
- ACTIVE:
  - Timeout counter counts up from 0.
  - Exit to RECOVER when any of these holds: rel[owner]=1; req[owner]=0; (TIMEOUT != 0 and count == TIMEOUT-1).
  - On a timeout exit, timeout_err=1 for exactly the first RECOVER cycle.
  - rel and rel-like pulses from non-owners are ignored in every state.
  - If rel and timeout coincide, it is a normal release and timeout_err=0.
- RECOVER:
  - gnt=0, ready=0, busy=1 for exactly one cycle, then IDLE.
  - Pointer = (owner+1) mod N, updated on entry to RECOVER. This includes aborts and timeouts.
- Fairness: a continuously requesting client waits at most N-1 ownership slots.
- owner holds its last value in IDLE. gnt is zero outside SETUP/ACTIVE. ready is high only in ACTIVE.
- Counters saturate and never wrap. SETUP_CYCLES=1 means ACTIVE on the cycle after grant.
- Reset mid-operation drops gnt/ready immediately (asynchronous) and clears the pointer.
- Requests arriving in non-IDLE states are not queued. Arbitration occurs only in IDLE, using req sampled there.

Test Plan:
- Reset, then req=4'b0001 held, rel[0] pulsed 2 cycles after ready -> gnt=0001 one cycle after req; ready after 3 more cycles; busy stays high through one RECOVER cycle; back to IDLE with owner=0.
- req=4'b1111 held, each owner pulses rel once ready -> grant order 0,1,2,3,0; every grant is one-hot; one idle-gap RECOVER cycle between owners.
- req=4'b0101 with pointer=1 after owner 0 releases -> next owner=2, not 0; then owner 0 again.
- TIMEOUT=8, req[1] held and never released -> ready high for exactly 8 cycles; timeout_err pulses 1 cycle; next grant goes to another requester if one is pending.
- req[3] dropped during SETUP -> RECOVER without ready ever asserting and with timeout_err=0; rel[2] pulsed by a non-owner during ACTIVE -> no effect.
- rst asserted asynchronously mid-ACTIVE -> gnt, ready and busy go 0 before the next clk edge; after release, arbitration restarts from pointer 0.
